led_metronome_gen: RTL and testbench

- Parametrised LED sweep generator ("metronome") for the board LED bar, clocked by the slow LED clock LEDclk.
- Moves a lit position across WIDTH LEDs at a programmable tempo. Supports bounce, rotate-left, rotate-right and bar-fill modes.
- Emits a one-cycle beat pulse at each turnaround or wrap, and counts beats for the display/score logic.

---
 rtl/led_metronome_gen_if.sv | 37 +++
 rtl/led_metronome_gen.sv | 197 +++++++++++++++++++
 tb/tb_led_metronome_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/led_metronome_gen_if.sv
//------------------------------------------------------------------------------
// Module   : led_metronome_gen_if
// Purpose  : Control/status bundle for the LED metronome. The controller side
//            (master) sets run, mode and tempo. The generator side (slave)
//            returns the LED pattern, position, direction and beat status.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface led_metronome_gen_if #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  localparam int POS_W = $clog2(WIDTH);

  logic             start;
  logic [1:0]       mode;
  logic [DIV_W-1:0] tempo;
  logic [WIDTH-1:0] LED;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             beat;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output start, mode, tempo,
    input  LED, pos, dir, beat, beat_cnt
  );

  modport slave (
    input  start, mode, tempo,
    output LED, pos, dir, beat, beat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/led_metronome_gen.sv
//------------------------------------------------------------------------------
// Module   : led_metronome_gen
// Purpose  : LED sweep "metronome" for the board LED bar. It moves a lit
//            position across WIDTH LEDs at a programmable tempo. Modes are
//            bounce, rotate-left, rotate-right and bar-fill bounce. It pulses
//            beat on each turnaround or wrap and counts the beats.
// Options  : `define LED_TRAIL_EN also lights the previous position in
//            modes 0-2, which gives a 2-LED trail.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_metronome_gen #(
  parameter int WIDTH     = 16,
  parameter int START_POS = 8,
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                LEDclk,
  input  logic                reset,
  led_metronome_gen_if.slave  bus
);

  localparam int POS_W = $clog2(WIDTH);

  localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTL   = 2'd1;
  localparam logic [1:0] MODE_ROTR   = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  logic [0:0]       state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [POS_W-1:0] pos_q,   pos_d;
  logic             dir_q,   dir_d;
  logic             beat_q,  beat_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] led_q,   led_d;

`ifdef LED_TRAIL_EN
  // The previous position and a flag that says whether a step has happened yet.
  logic [POS_W-1:0] prev_q,  prev_d;
  logic             trail_q, trail_d;
`endif

  // Next-state logic: idle values are the defaults, and RUN overrides them.
  always_comb begin
    state_d = ST_IDLE;
    mode_d  = mode_q;
    div_d   = '0;
    pos_d   = POS_START;
    dir_d   = 1'b1;
    beat_d  = 1'b0;
    cnt_d   = '0;
`ifdef LED_TRAIL_EN
    prev_d  = POS_START;
    trail_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          mode_d  = bus.mode;
        end
      end
      default: begin
        // Dropping start sends the block back to the idle defaults. Any step
        // that would have happened in the same cycle is discarded.
        if (bus.start) begin
          state_d = ST_RUN;
          pos_d   = pos_q;
          dir_d   = dir_q;
          cnt_d   = cnt_q;
`ifdef LED_TRAIL_EN
          prev_d  = prev_q;
          trail_d = trail_q;
`endif
          // The compare uses the live tempo. If the count has already passed
          // the tempo, it wraps around before the next step.
          if (div_q == bus.tempo) begin
            div_d = '0;
`ifdef LED_TRAIL_EN
            prev_d  = pos_q;
            trail_d = 1'b1;
`endif
            case (mode_q)
              MODE_ROTL: begin
                dir_d = 1'b1;
                if (pos_q == POS_MAX) begin
                  pos_d  = '0;
                  beat_d = 1'b1;
                end else begin
                  pos_d = pos_q + POS_W'(1);
                end
              end
              MODE_ROTR: begin
                dir_d = 1'b0;
                if (pos_q == '0) begin
                  pos_d  = POS_MAX;
                  beat_d = 1'b1;
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
              default: begin
                // Bounce and bar-fill: stay at the end for one step while the
                // direction reverses.
                if (dir_q && (pos_q == POS_MAX)) begin
                  dir_d  = 1'b0;
                  beat_d = 1'b1;
                end else if (!dir_q && (pos_q == '0)) begin
                  dir_d  = 1'b1;
                  beat_d = 1'b1;
                end else if (dir_q) begin
                  pos_d = pos_q + POS_W'(1);
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
            endcase
            cnt_d = cnt_q + CNT_W'(beat_d);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
    endcase
  end

  // LED pattern for the next cycle: a thermometer in bar-fill, otherwise a single LED.
  always_comb begin
    led_d = '0;
    if ((state_d == ST_RUN) && (mode_d == MODE_FILL)) begin
      for (int i = 0; i < WIDTH; i++) begin
        led_d[i] = (i <= int'(pos_d));
      end
    end else begin
      led_d[pos_d] = 1'b1;
`ifdef LED_TRAIL_EN
      if (trail_d) begin
        led_d[prev_d] = 1'b1;
      end
`endif
    end
  end

  // State and output registers, with synchronous reset to the idle values.
  always_ff @(posedge LEDclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BOUNCE;
      div_q   <= '0;
      pos_q   <= POS_START;
      dir_q   <= 1'b1;
      beat_q  <= 1'b0;
      cnt_q   <= '0;
      led_q   <= WIDTH'(1) << START_POS;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

`ifdef LED_TRAIL_EN
  // Trail registers. They are cleared with the rest of the idle state.
  always_ff @(posedge LEDclk) begin
    if (reset) begin
      prev_q  <= POS_START;
      trail_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      trail_q <= trail_d;
    end
  end
`endif

  assign bus.LED      = led_q;
  assign bus.pos      = pos_q;
  assign bus.dir      = dir_q;
  assign bus.beat     = beat_q;
  assign bus.beat_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_led_metronome_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_led_metronome_gen
// Purpose  : Directed, self-checking bench for led_metronome_gen (default
//            build, LED_TRAIL_EN undefined).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_metronome_gen;

  logic LEDclk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  led_metronome_gen_if #(.WIDTH(16), .DIV_W(8), .CNT_W(8)) bus ();

  led_metronome_gen #(
    .WIDTH(16), .START_POS(8), .DIV_W(8), .CNT_W(8)
  ) dut (
    .LEDclk (LEDclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 LEDclk = ~LEDclk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge LEDclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.tempo = 8'd0;
    tick();
    tick();
    check("rst_led",  32'(bus.LED), 32'h0100);
    check("rst_pos",  32'(bus.pos), 32'd8);
    check("rst_dir",  32'(bus.dir), 32'd1);
    check("rst_beat", 32'(bus.beat), 32'd0);
    check("rst_cnt",  32'(bus.beat_cnt), 32'd0);

    // Bounce, tempo 0
    reset     = 1'b0;
    bus.start = 1'b1;
    tick();
    check("bnc_enter_led", 32'(bus.LED), 32'h0100);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("bnc_up_led", 32'(bus.LED), 32'h0100 << k);
      check("bnc_up_pos", 32'(bus.pos), 32'(8 + k));
    end
    check("bnc_top_nobeat", 32'(bus.beat), 32'd0);
    tick();
    check("bnc_dwell_led",  32'(bus.LED), 32'h8000);
    check("bnc_dwell_beat", 32'(bus.beat), 32'd1);
    check("bnc_dwell_dir",  32'(bus.dir), 32'd0);
    check("bnc_dwell_cnt",  32'(bus.beat_cnt), 32'd1);
    tick();
    check("bnc_down_led",  32'(bus.LED), 32'h4000);
    check("bnc_down_beat", 32'(bus.beat), 32'd0);
    tick();
    tick();
    check("bnc_pos12", 32'(bus.pos), 32'd12);

    // Reset while running
    reset = 1'b1;
    tick();
    check("rrun_led",  32'(bus.LED), 32'h0100);
    check("rrun_pos",  32'(bus.pos), 32'd8);
    check("rrun_dir",  32'(bus.dir), 32'd1);
    check("rrun_cnt",  32'(bus.beat_cnt), 32'd0);
    check("rrun_beat", 32'(bus.beat), 32'd0);

    // Bounce, tempo 3: one step every 4 cycles, full loop gives 2 beats
    bus.tempo = 8'd3;
    reset     = 1'b0;
    tick();
    check("t3_enter_pos", 32'(bus.pos), 32'd8);
    repeat (3) tick();
    check("t3_hold_pos", 32'(bus.pos), 32'd8);
    tick();
    check("t3_step_pos", 32'(bus.pos), 32'd9);
    repeat (124) tick();
    check("t3_loop_pos", 32'(bus.pos), 32'd8);
    check("t3_loop_dir", 32'(bus.dir), 32'd1);
    check("t3_loop_cnt", 32'(bus.beat_cnt), 32'd2);
    bus.start = 1'b0;
    tick();
    check("t3_idle_cnt", 32'(bus.beat_cnt), 32'd0);
    check("t3_idle_led", 32'(bus.LED), 32'h0100);

    // Rotate-left
    bus.mode  = 2'd1;
    bus.tempo = 8'd0;
    bus.start = 1'b1;
    tick();
    repeat (7) tick();
    check("rotl_top_pos", 32'(bus.pos), 32'd15);
    check("rotl_top_led", 32'(bus.LED), 32'h8000);
    check("rotl_top_dir", 32'(bus.dir), 32'd1);
    tick();
    check("rotl_wrap_pos",  32'(bus.pos), 32'd0);
    check("rotl_wrap_led",  32'(bus.LED), 32'h0001);
    check("rotl_wrap_beat", 32'(bus.beat), 32'd1);
    check("rotl_wrap_cnt",  32'(bus.beat_cnt), 32'd1);
    bus.start = 1'b0;
    tick();
    check("rotl_idle_pos", 32'(bus.pos), 32'd8);

    // Rotate-right
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    tick();
    repeat (8) tick();
    check("rotr_bot_pos", 32'(bus.pos), 32'd0);
    check("rotr_bot_dir", 32'(bus.dir), 32'd0);
    tick();
    check("rotr_wrap_pos",  32'(bus.pos), 32'd15);
    check("rotr_wrap_led",  32'(bus.LED), 32'h8000);
    check("rotr_wrap_beat", 32'(bus.beat), 32'd1);
    repeat (15) tick();
    check("rotr_bot2_pos", 32'(bus.pos), 32'd0);
    // Drop start on a cycle that would otherwise step and wrap: idle wins
    bus.start = 1'b0;
    tick();
    check("simul_beat", 32'(bus.beat), 32'd0);
    check("simul_cnt",  32'(bus.beat_cnt), 32'd0);
    check("simul_pos",  32'(bus.pos), 32'd8);

    // Bar-fill
    bus.mode  = 2'd3;
    bus.start = 1'b1;
    tick();
    check("fill_enter_led", 32'(bus.LED), 32'h01FF);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("fill_up_led", 32'(bus.LED), (32'h1 << (9 + k)) - 32'h1);
    end
    tick();
    check("fill_dwell_led",  32'(bus.LED), 32'hFFFF);
    check("fill_dwell_beat", 32'(bus.beat), 32'd1);
    tick();
    check("fill_down_led", 32'(bus.LED), 32'h7FFF);
    bus.mode = 2'd1;
    tick();
    check("fill_modechg_led", 32'(bus.LED), 32'h3FFF);
    bus.start = 1'b0;
    tick();
    check("fill_idle_led", 32'(bus.LED), 32'h0100);
    check("fill_idle_pos", 32'(bus.pos), 32'd8);

    // Tempo lowered below the running count: divider wraps before stepping
    bus.mode  = 2'd0;
    bus.tempo = 8'd3;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    bus.tempo = 8'd1;
    repeat (255) tick();
    check("wrap_hold_pos", 32'(bus.pos), 32'd8);
    tick();
    check("wrap_step_pos", 32'(bus.pos), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
